// File: rtl/mp5_pkg.sv
// rtl/mp5_pkg.sv - shared MP5 stage types: sizing, packet/entry records, scheduler entry
package mp5_pkg;

   localparam int NUM_PIPELINES = 2;
   localparam int FIFO_SIZE     = 8;
   localparam int TS_W          = 64;
   localparam int PKT_W         = 512;
   // fifo_id is sized for the largest supported stage (16 pipelines)
   localparam int MAX_NP_W      = 4;

   typedef logic [PKT_W-1:0] Packet;

   typedef struct packed {
      Packet           pkt;
      logic [TS_W-1:0] ts;
   } FIFO_Entry;

   typedef struct packed {
      logic                valid;
      logic [MAX_NP_W-1:0] fifo_id;
      FIFO_Entry           entry;
   } Entry;

   typedef struct packed {
      logic                valid;
      logic [TS_W-1:0]     timestamp;
      logic [MAX_NP_W-1:0] fifo_id;
   } sched_entry_t;

endpackage

// File: rtl/mp5_min_ts_tree.sv
// rtl/mp5_min_ts_tree.sv - combinational oldest-head selector with round-robin tie-break
module mp5_min_ts_tree import mp5_pkg::*; #(
   parameter  int NP  = NUM_PIPELINES,
   localparam int NPW = $clog2(NP)
) (
   input  sched_entry_t     entries [NP],
   input  logic [NPW-1:0]   rr_ptr,
   output logic             win_valid,
   output logic [NPW-1:0]   win_id
);

   localparam int LVLS = $clog2(NP);

   sched_entry_t lvl [LVLS+1][NP];

   function automatic logic [NPW-1:0] rr_dist(input logic [MAX_NP_W-1:0] id,
                                              input logic [NPW-1:0] rr);
      return id[NPW-1:0] - rr;
   endfunction

   // Ordering is (timestamp, distance from rr_ptr), a total order, so any tree shape finds the same winner
   function automatic sched_entry_t pick(input sched_entry_t a, input sched_entry_t b,
                                         input logic [NPW-1:0] rr);
      if (!b.valid)
         return a;
      if (!a.valid)
         return b;
      if (a.timestamp != b.timestamp)
         return (a.timestamp < b.timestamp) ? a : b;
      return (rr_dist(a.fifo_id, rr) < rr_dist(b.fifo_id, rr)) ? a : b;
   endfunction

   always_comb begin
      for (int l = 0; l <= LVLS; l++)
         for (int i = 0; i < NP; i++)
            lvl[l][i] = '0;
      for (int i = 0; i < NP; i++)
         lvl[0][i] = entries[i];
      for (int l = 0; l < LVLS; l++)
         for (int i = 0; i < (NP >> (l + 1)); i++)
            lvl[l+1][i] = pick(lvl[l][2*i], lvl[l][2*i+1], rr_ptr);
      win_valid = lvl[LVLS][0].valid;
      win_id    = lvl[LVLS][0].fifo_id[NPW-1:0];
   end

endmodule

// File: rtl/mp5_ts_pop_scheduler.sv
// rtl/mp5_ts_pop_scheduler.sv - per-stage FIFO pointer owner and timestamp-ordered pop scheduler
module mp5_ts_pop_scheduler #(
   parameter  int NUM_PIPELINES = mp5_pkg::NUM_PIPELINES,
   parameter  int FIFO_SIZE     = mp5_pkg::FIFO_SIZE,
   parameter  int TS_W          = mp5_pkg::TS_W,
   localparam int NP            = NUM_PIPELINES,
   localparam int AW            = $clog2(FIFO_SIZE),
   localparam int NPW           = $clog2(NUM_PIPELINES)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NP-1:0]          push_valid,
   output logic [NP-1:0]          push_ready,
   output logic [NP-1:0][AW-1:0]  push_addr,
   output logic                   pop_valid,
   output logic [NPW-1:0]         pop_fifo_id,
   output logic [AW-1:0]          pop_addr,
   input  logic                   pop_ready,
   output logic [NP-1:0][AW:0]    occupancy
);

   import mp5_pkg::*;

   logic [AW:0]      head_q [NP];
   logic [AW:0]      head_d [NP];
   logic [AW:0]      tail_q [NP];
   logic [AW:0]      tail_d [NP];
   logic [TS_W-1:0]  ts_mem_q [NP][FIFO_SIZE];
   logic [TS_W-1:0]  ts_mem_d [NP][FIFO_SIZE];
   logic [TS_W-1:0]  curr_time_q, curr_time_d;
   logic [NPW-1:0]   rr_ptr_q, rr_ptr_d;

   logic [NP-1:0]    full;
   logic             win_valid;
   logic [NPW-1:0]   win_id;
   logic             pop_fire;
   sched_entry_t     entries [NP];

   // Everything the datapath sees is derived from registered state only
   always_comb begin
      for (int i = 0; i < NP; i++) begin
         occupancy[i]          = tail_q[i] - head_q[i];
         full[i]               = (occupancy[i] == (AW+1)'(FIFO_SIZE));
         push_addr[i]          = tail_q[i][AW-1:0];
         entries[i]            = '0;
         entries[i].valid      = (head_q[i] != tail_q[i]);
         entries[i].timestamp[TS_W-1:0] = ts_mem_q[i][head_q[i][AW-1:0]];
         entries[i].fifo_id    = MAX_NP_W'(i);
      end
      push_ready  = ~full;
      pop_valid   = win_valid;
      pop_fifo_id = win_id;
      pop_addr    = head_q[win_id][AW-1:0];
   end

   mp5_min_ts_tree #(.NP(NP)) u_min_ts_tree (
      .entries   (entries),
      .rr_ptr    (rr_ptr_q),
      .win_valid (win_valid),
      .win_id    (win_id)
   );

   always_comb begin
      head_d      = head_q;
      tail_d      = tail_q;
      ts_mem_d    = ts_mem_q;
      rr_ptr_d    = rr_ptr_q;
      curr_time_d = curr_time_q + 1'b1;
      pop_fire    = win_valid & pop_ready;
      if (pop_fire) begin
         head_d[win_id] = head_q[win_id] + 1'b1;
         rr_ptr_d       = win_id + 1'b1;
      end
      // Full gates push on registered occupancy, so a same-cycle pop never frees a slot for it
      for (int i = 0; i < NP; i++) begin
         if (push_valid[i] && !full[i]) begin
            ts_mem_d[i][tail_q[i][AW-1:0]] = curr_time_q;
            tail_d[i]                      = tail_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q      <= '{default: '0};
         tail_q      <= '{default: '0};
         curr_time_q <= '0;
         rr_ptr_q    <= '0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         curr_time_q <= curr_time_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      ts_mem_q <= ts_mem_d;
   end

endmodule

// File: tb/tb_mp5_ts_pop_scheduler.sv
// tb/tb_mp5_ts_pop_scheduler.sv - self-checking bench for mp5_ts_pop_scheduler
module tb_mp5_ts_pop_scheduler;

   localparam int NP = 2;
   localparam int FS = 8;
   localparam int AW = 3;

   logic                  clk;
   logic                  rst;
   logic [NP-1:0]         push_valid;
   logic [NP-1:0]         push_ready;
   logic [NP-1:0][AW-1:0] push_addr;
   logic                  pop_valid;
   logic [0:0]            pop_fifo_id;
   logic [AW-1:0]         pop_addr;
   logic                  pop_ready;
   logic [NP-1:0][AW:0]   occupancy;

   mp5_ts_pop_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .push_valid  (push_valid),
      .push_ready  (push_ready),
      .push_addr   (push_addr),
      .pop_valid   (pop_valid),
      .pop_fifo_id (pop_fifo_id),
      .pop_addr    (pop_addr),
      .pop_ready   (pop_ready),
      .occupancy   (occupancy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total;
   int bad;

   // Reference model: per-FIFO queues of arrival times plus push/pop counts
   longint mq [NP][$];
   int     hcnt [NP];
   int     tcnt [NP];
   int     rr;
   longint mtime;

   typedef struct {
      logic [1:0] pv;
      logic       pr;
      logic       ev;
      int         eid;
      int         eaddr;
      int         eocc0;
      int         eocc1;
   } vec_t;

   vec_t tbl [19];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < NP; i++) begin
         mq[i].delete();
         hcnt[i] = 0;
         tcnt[i] = 0;
      end
      rr    = 0;
      mtime = 0;
   endtask

   // Oldest head wins; scanning from rr with strict less-than keeps the first tied index
   function automatic int m_win();
      int best;
      best = -1;
      for (int k = 0; k < NP; k++) begin
         int idx;
         idx = (rr + k) % NP;
         if (mq[idx].size() != 0)
            if (best < 0 || mq[idx][0] < mq[best][0])
               best = idx;
      end
      return best;
   endfunction

   task automatic step(input logic [NP-1:0] pv, input logic pr);
      int w;
      logic [NP-1:0] pf;
      w = m_win();
      chk("pop_valid", 64'(pop_valid), 64'(w >= 0));
      if (w >= 0) begin
         chk("pop_fifo_id", 64'(pop_fifo_id), 64'(w));
         chk("pop_addr", 64'(pop_addr), 64'(hcnt[w] % FS));
      end
      for (int i = 0; i < NP; i++) begin
         chk($sformatf("push_ready[%0d]", i), 64'(push_ready[i]), 64'(mq[i].size() < FS));
         chk($sformatf("occupancy[%0d]", i), 64'(occupancy[i]), 64'(mq[i].size()));
         chk($sformatf("push_addr[%0d]", i), 64'(push_addr[i]), 64'(tcnt[i] % FS));
      end
      push_valid = pv;
      pop_ready  = pr;
      for (int i = 0; i < NP; i++)
         pf[i] = pv[i] && (mq[i].size() < FS);
      if (w >= 0 && pr) begin
         void'(mq[w].pop_front());
         hcnt[w]++;
         rr = (w + 1) % NP;
      end
      for (int i = 0; i < NP; i++)
         if (pf[i]) begin
            mq[i].push_back(mtime);
            tcnt[i]++;
         end
      mtime++;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      m_reset();

      //             pv     pr    ev    id addr occ0 occ1
      tbl[0]  = '{2'b10, 1'b0, 1'b0, 0, 0, 0, 0};
      tbl[1]  = '{2'b00, 1'b0, 1'b1, 1, 0, 0, 1};
      tbl[2]  = '{2'b01, 1'b0, 1'b1, 1, 0, 0, 1};
      tbl[3]  = '{2'b00, 1'b0, 1'b1, 1, 0, 1, 1};
      tbl[4]  = '{2'b00, 1'b1, 1'b1, 1, 0, 1, 1};
      tbl[5]  = '{2'b00, 1'b0, 1'b1, 0, 0, 1, 0};
      tbl[6]  = '{2'b00, 1'b1, 1'b1, 0, 0, 1, 0};
      tbl[7]  = '{2'b11, 1'b0, 1'b0, 0, 0, 0, 0};
      tbl[8]  = '{2'b00, 1'b1, 1'b1, 1, 1, 1, 1};
      tbl[9]  = '{2'b00, 1'b1, 1'b1, 0, 1, 1, 0};
      tbl[10] = '{2'b10, 1'b0, 1'b0, 0, 0, 0, 0};
      tbl[11] = '{2'b00, 1'b1, 1'b1, 1, 2, 0, 1};
      tbl[12] = '{2'b11, 1'b0, 1'b0, 0, 0, 0, 0};
      tbl[13] = '{2'b00, 1'b1, 1'b1, 0, 2, 1, 1};
      tbl[14] = '{2'b00, 1'b1, 1'b1, 1, 3, 0, 1};
      tbl[15] = '{2'b11, 1'b0, 1'b0, 0, 0, 0, 0};
      tbl[16] = '{2'b00, 1'b1, 1'b1, 0, 3, 1, 1};
      tbl[17] = '{2'b00, 1'b1, 1'b1, 1, 4, 0, 1};
      tbl[18] = '{2'b00, 1'b0, 1'b0, 0, 0, 0, 0};

      rst        = 1'b1;
      push_valid = '0;
      pop_ready  = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset pop_valid", 64'(pop_valid), 64'd0);
      chk("reset push_ready", 64'(push_ready), 64'd3);
      chk("reset occupancy", 64'(occupancy), 64'd0);
      rst = 1'b0;

      for (int r = 0; r < 19; r++) begin
         chk($sformatf("tbl%0d pop_valid", r), 64'(pop_valid), 64'(tbl[r].ev));
         if (tbl[r].ev) begin
            chk($sformatf("tbl%0d pop_fifo_id", r), 64'(pop_fifo_id), 64'(tbl[r].eid));
            chk($sformatf("tbl%0d pop_addr", r), 64'(pop_addr), 64'(tbl[r].eaddr));
         end
         chk($sformatf("tbl%0d occ0", r), 64'(occupancy[0]), 64'(tbl[r].eocc0));
         chk($sformatf("tbl%0d occ1", r), 64'(occupancy[1]), 64'(tbl[r].eocc1));
         step(tbl[r].pv, tbl[r].pr);
      end

      repeat (8) step(2'b01, 1'b0);
      chk("full occ0", 64'(occupancy[0]), 64'd8);
      chk("full push_ready0", 64'(push_ready[0]), 64'd0);
      step(2'b01, 1'b1);
      chk("full pop no enqueue occ0", 64'(occupancy[0]), 64'd7);
      repeat (7) step(2'b00, 1'b1);

      step(2'b01, 1'b0);
      step(2'b10, 1'b0);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("hold%0d pop_fifo_id", k), 64'(pop_fifo_id), 64'd0);
         step(2'b11, 1'b0);
      end
      chk("hold first pop fifo", 64'(pop_fifo_id), 64'd0);
      repeat (8) step(2'b00, 1'b1);

      for (int k = 0; k < 300; k++)
         step(NP'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

      #2 rst = 1'b1;
      #1;
      chk("async pop_valid", 64'(pop_valid), 64'd0);
      chk("async push_ready", 64'(push_ready), 64'd3);
      chk("async occupancy", 64'(occupancy), 64'd0);
      chk("async push_addr", 64'(push_addr), 64'd0);
      push_valid = '0;
      pop_ready  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      m_reset();

      for (int k = 0; k < 21; k++) begin
         chk($sformatf("pair%0d push_addr0", k), 64'(push_addr[0]), 64'(k % FS));
         if (k > 0)
            chk($sformatf("pair%0d pop_addr", k), 64'(pop_addr), 64'((k - 1) % FS));
         step(2'b01, 1'b1);
      end

      for (int k = 0; k < 100; k++)
         step(NP'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
